// File: rtl/aircon_mode_ctrl.sv
// aircon_mode_ctrl
// Front-panel mode controller: turns debounced button pulses into the one-hot
// mode code and turbo flag for the bar-graph display. It also handles the
// compressor restart lockout, the pending cool request that resumes on its
// own, and the turbo timer that clears itself.
module aircon_mode_ctrl #(
  parameter int RESTART_TICKS = 3,
  parameter int TURBO_TICKS   = 10,
  parameter int CNT_W         = 8
) (
  input  logic       Clk_In,
  input  logic       Rst_In,
  input  logic       Tick_In,
  input  logic       Pwr_In,
  input  logic       Up_In,
  input  logic       Down_In,
  input  logic       TurboBtn_In,
  output logic [3:0] Thermo_Out,
  output logic       Turbo_Out,
  output logic       Lock_Out,
  output logic       Pend_Out
);

  // The state encoding is the display code itself, so the state register
  // drives Thermo_Out directly.
  typedef enum logic [3:0] {
    S_OFF       = 4'b0000,
    S_LOW_FAN   = 4'b0001,
    S_HIGH_FAN  = 4'b0010,
    S_LOW_COOL  = 4'b0100,
    S_HIGH_COOL = 4'b1000
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO    = '0;
  localparam logic [CNT_W-1:0] RESTART_VAL = CNT_W'(RESTART_TICKS);
  localparam logic [CNT_W-1:0] TURBO_VAL   = CNT_W'(TURBO_TICKS);

  state_t           state_q, state_d;
  logic             pend_q, pend_d;
  logic             turbo_q, turbo_d;
  logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
  logic [CNT_W-1:0] turbo_cnt_q, turbo_cnt_d;

  logic move_up;
  logic move_down;
  logic locked;
  logic cool_now;
  logic cool_next;
  logic state_change;
  logic turbo_allowed;

  // Up and Down together cancel each other out; Pwr is handled separately.
  assign move_up   = Up_In & ~Down_In;
  assign move_down = Down_In & ~Up_In;

  // Buttons see the lockout value from before the edge.
  assign locked = (lock_cnt_q != CNT_ZERO);

  assign cool_now      = (state_q == S_LOW_COOL) || (state_q == S_HIGH_COOL);
  assign cool_next     = (state_d == S_LOW_COOL) || (state_d == S_HIGH_COOL);
  assign state_change  = (state_d != state_q);
  assign turbo_allowed = (state_q == S_HIGH_FAN) || (state_q == S_HIGH_COOL);

  // Next-state and pending-request logic: Pwr, then Down, then the automatic
  // resume, then Up.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    if (Pwr_In) begin
      pend_d = 1'b0;
      if (state_q == S_OFF) begin
        state_d = S_LOW_FAN;
      end else begin
        state_d = S_OFF;
      end
    end else if (move_down) begin
      pend_d = 1'b0;
      case (state_q)
        S_HIGH_COOL: state_d = S_LOW_COOL;
        S_LOW_COOL:  state_d = S_HIGH_FAN;
        S_HIGH_FAN:  state_d = S_LOW_FAN;
        default:     state_d = state_q;
      endcase
    end else if (pend_q && (state_q == S_HIGH_FAN) && !locked) begin
      // The lockout expired on an earlier edge, so the held request resumes.
      state_d = S_LOW_COOL;
      pend_d  = 1'b0;
    end else if (move_up) begin
      case (state_q)
        S_LOW_FAN:  state_d = S_HIGH_FAN;
        S_HIGH_FAN: begin
          if (locked) begin
            pend_d = 1'b1;
          end else begin
            state_d = S_LOW_COOL;
          end
        end
        S_LOW_COOL: state_d = S_HIGH_COOL;
        default:    state_d = state_q;
      endcase
    end
  end

  // Lockout counter: it is loaded when the state leaves cooling, and a load
  // wins over a tick in the same cycle.
  always_comb begin
    lock_cnt_d = lock_cnt_q;
    if (cool_now && !cool_next) begin
      lock_cnt_d = RESTART_VAL;
    end else if (Tick_In && locked) begin
      lock_cnt_d = lock_cnt_q - CNT_ONE;
    end
  end

  // Turbo flag and timer: a state change clears them. Otherwise the button
  // toggles turbo in the high modes, or else a tick runs the timer down.
  always_comb begin
    turbo_d     = turbo_q;
    turbo_cnt_d = turbo_cnt_q;
    if (state_change) begin
      turbo_d     = 1'b0;
      turbo_cnt_d = CNT_ZERO;
    end else if (TurboBtn_In && turbo_allowed) begin
      if (turbo_q) begin
        turbo_d     = 1'b0;
        turbo_cnt_d = CNT_ZERO;
      end else begin
        turbo_d     = 1'b1;
        turbo_cnt_d = TURBO_VAL;
      end
    end else if (Tick_In && (turbo_cnt_q != CNT_ZERO)) begin
      turbo_cnt_d = turbo_cnt_q - CNT_ONE;
      if (turbo_cnt_q == CNT_ONE) begin
        turbo_d = 1'b0;
      end
    end
  end

  // State, request, flag and counter registers with synchronous reset.
  always_ff @(posedge Clk_In) begin
    if (Rst_In) begin
      state_q     <= S_OFF;
      pend_q      <= 1'b0;
      turbo_q     <= 1'b0;
      lock_cnt_q  <= CNT_ZERO;
      turbo_cnt_q <= CNT_ZERO;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      turbo_q     <= turbo_d;
      lock_cnt_q  <= lock_cnt_d;
      turbo_cnt_q <= turbo_cnt_d;
    end
  end

  assign Thermo_Out = state_q;
  assign Turbo_Out  = turbo_q;
  assign Lock_Out   = locked;
  assign Pend_Out   = pend_q;

endmodule
